reduce_tree_pipe: RTL and testbench
===================================

Name: reduce_tree_pipe

Overview:
- Parametrised, pipelined N-input bitwise reduction tree for the datapath. It is the successor of the fixed 8-input OR tree.
- Reduction modes: OR, AND, XOR and NOR. NOR provides the zero flag.
- A register slice is placed every REG_EVERY tree levels, and valid/ready handshakes wrap the pipeline.
- Used by the ALU flag logic and by the branch-compare unit, where a single-cycle combinational tree breaks timing.

Parameters:
- WIDTH, 32: input vector width. Must be a power of two, 2 to 256. Elaboration fails otherwise.
- REG_EVERY, 1: number of tree levels between pipeline registers. Range 1 to log2(WIDTH).
- Derived LEVELS = log2(WIDTH).
- Derived STAGES = ceil(LEVELS/REG_EVERY). This is the latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data and in_op are valid.
- in_ready  output  1  pipeline can accept this cycle.
- in_data  input  WIDTH  vector to reduce.
- in_op  input  2  00 OR, 01 AND, 10 XOR, 11 NOR.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  consumer accepts.
- out_bit  output  1  reduction result.
- out_op  output  2  op that produced out_bit, echoed for tagging.

Behaviour:
- Reset: asynchronous assert on rst_n=0 clears every stage valid bit, every stage data/op register, out_bit=0 and out_op=00. Release is synchronous to clk.
- Reset mid-operation: all in-flight items are discarded. No output is produced for them.
- Tree:
  - Level k combines pairs of level k-1 nodes using the base op (OR for 00/11, AND for 01, XOR for 10).
  - The NOR inversion is applied only once, after the final level, before out_bit.
  - Op travels with the data through every stage.
- Stage s holds the nodes after level min(s*REG_EVERY, LEVELS), plus v[s] and op[s]. The last stage holds one bit.
- Handshake:
  - Transfer in occurs when in_valid and in_ready are both high.
  - Transfer out occurs when out_valid and out_ready are both high.
  - out_valid = v[STAGES-1].
  - Stage s advances (loads from s-1, or from the input for s=0) when !v[s] or when stage s+1 advances. The last stage's "next advances" is out_ready.
  - in_ready = stage-0 advance condition. It is combinational from out_ready through the chain; no registered skid.
  - v[s] next = v[s-1] (in_valid for s=0) when stage s advances; otherwise it holds.
  - Registers in non-advancing stages hold. Data into a bubble is loaded even if its valid is 0.
- Latency: an item accepted at cycle t appears with out_valid=1 at cycle t+STAGES if never stalled.
- Throughput: one item per cycle with out_ready held high.
- Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Stall: with out_ready=0, out_valid, out_bit and out_op are stable until accepted. The pipeline fills to STAGES items, then in_ready=0.
- Simultaneous accept-out and accept-in when full: both occur in the same cycle and the pipeline stays full.
- in_valid=0 while in_ready=1: a bubble is inserted. in_data is ignored.
- Inputs are sampled only on the transfer cycle. Changing in_data while in_ready=0 has no effect.
- Identity padding is not needed because WIDTH is a power of two.

Decomposition:
- Shared package constants: REDOP_OR=2'b00, REDOP_AND=2'b01, REDOP_XOR=2'b10, REDOP_NOR=2'b11. Also a clog2 function shared by other parametrised blocks.
- Sub-module reduce_level, parametrised by IN_W:
  - One combinational tree level: IN_W inputs to IN_W/2 outputs, selected by a 2-bit op.
  - Built from the existing 2-input gate cells via generate.
  - The top level instantiates LEVELS of them and inserts registers per REG_EVERY.

Test Plan:
- Reset and idle:
  - Stimulus: WIDTH=8, REG_EVERY=1 (STAGES=3). Hold rst_n=0, then release.
  - Required: out_valid=0, out_bit=0, out_op=00, in_ready=1.
- Latency:
  - Stimulus: at cycle t, send in_data=8'h00 with op=NOR, out_ready=1.
  - Required: at t+3, out_valid=1 and out_bit=1. Then 8'h10 with NOR gives out_bit=0 at t+4.
- Streaming:
  - Stimulus: back-to-back items (8'hFF AND), (8'hFE AND), (8'h07 XOR), (8'h80 OR).
  - Required: consecutive outputs 1, 0, 1, 1 with no gaps, and out_op echoing 01, 01, 10, 00.
- Backpressure:
  - Stimulus: out_ready=0 while sending 4 items.
  - Required: exactly 3 accepted, then in_ready=0. The output holds the first result stably. Raising out_ready for 1 cycle pops one item and accepts one more in the same cycle.
- Mid-operation reset:
  - Stimulus: pulse rst_n low asynchronously with 2 items in flight.
  - Required: out_valid drops immediately, and no stale outputs appear after release.
- Parameter sweep:
  - Stimulus: WIDTH=32 with REG_EVERY=2 (STAGES=3) and WIDTH=32 with REG_EVERY=5 (STAGES=1), 1000 random vectors and ops each.
  - Required: outputs match a reference model, with latency 3 and 1 respectively.

Source files
------------

// File: rtl/reduce_tree_pipe_pkg.sv
// Shared reduction-op encodings and elaboration helpers for the
// parametrised reduction datapath blocks.
package reduce_tree_pipe_pkg;

  typedef enum logic [1:0] {
    REDOP_OR  = 2'b00,
    REDOP_AND = 2'b01,
    REDOP_XOR = 2'b10,
    REDOP_NOR = 2'b11
  } redop_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reduce_tree_pipe_level.sv
// One combinational tree level: IN_W nodes pairwise reduced to IN_W/2
// using the base op (NOR shares the OR gates; inversion happens at the root).
module reduce_level
  import reduce_tree_pipe_pkg::*;
#(
  parameter int unsigned IN_W = 2
) (
  input  logic [1:0]        op,
  input  logic [IN_W-1:0]   in_data,
  output logic [IN_W/2-1:0] out_data
);

  for (genvar i = 0; i < IN_W / 2; i++) begin : g_pair
    logic a;
    logic b;
    logic r;

    assign a = in_data[2*i];
    assign b = in_data[2*i+1];

    always_comb begin
      case (op)
        REDOP_AND: r = a & b;
        REDOP_XOR: r = a ^ b;
        default:   r = a | b;
      endcase
    end

    assign out_data[i] = r;
  end

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined WIDTH-input bitwise reduction tree (OR/AND/XOR/NOR) with a
// register slice every REG_EVERY levels and a valid/ready handshake.
module reduce_tree_pipe
  import reduce_tree_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [1:0]       out_op
);

  localparam int unsigned LEVELS = clog2(WIDTH);
  localparam int unsigned STAGES = (LEVELS + REG_EVERY - 1) / REG_EVERY;
  localparam logic [STAGES-1:0] ALL_ONES = '1;

  if ((WIDTH < 2) || (WIDTH > 256) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("reduce_tree_pipe: WIDTH must be a power of two in 2..256");
  end
  if ((REG_EVERY < 1) || (REG_EVERY > LEVELS)) begin : g_bad_reg_every
    $error("reduce_tree_pipe: REG_EVERY must be in 1..log2(WIDTH)");
  end

  logic [STAGES-1:0]       v_q, v_d;
  logic [STAGES-1:0][1:0]  op_q, op_d;
  logic [STAGES-1:0]       adv;
  logic [STAGES:0]         v_chain;
  logic [STAGES:0][1:0]    op_chain;

  // Index s of the chains is what stage s loads from; the top entry is the output.
  assign v_chain  = {v_q, in_valid};
  assign op_chain = {op_q, in_op};

  // The ripple "!v[s] || adv[s+1]" is flattened: stage s advances when the
  // consumer takes the head or any stage from s to the output is empty.
  always_comb begin
    adv = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      adv[s] = out_ready || !(&(v_q | ~(ALL_ONES << s)));
    end
  end

  always_comb begin
    v_d  = v_q;
    op_d = op_q;
    for (int unsigned s = 0; s < STAGES; s++) begin
      if (adv[s]) begin
        v_d[s]  = v_chain[s];
        op_d[s] = op_chain[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      op_q <= '0;
    end else begin
      v_q  <= v_d;
      op_q <= op_d;
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned IN_W = WIDTH >> (k - 1);
    localparam int unsigned SIDX = (k - 1) / REG_EVERY;

    logic [IN_W-1:0]   lin;
    logic [IN_W/2-1:0] lout;
    logic [IN_W/2-1:0] lnext;
    logic [1:0]        lop;

    if (k == 1) begin : g_src_in
      assign lin = in_data;
    end else begin : g_src_lvl
      assign lin = g_lvl[k-1].lnext;
    end

    assign lop = op_chain[SIDX];

    reduce_level #(
      .IN_W(IN_W)
    ) u_level (
      .op      (lop),
      .in_data (lin),
      .out_data(lout)
    );

    if (((k % REG_EVERY) == 0) || (k == LEVELS)) begin : g_reg
      logic [IN_W/2-1:0] data_q, data_d;

      always_comb data_d = adv[SIDX] ? lout : data_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
      end

      assign lnext = data_q;
    end else begin : g_comb
      assign lnext = lout;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_chain[STAGES];
  assign out_op    = op_chain[STAGES];
  assign out_bit   = (op_chain[STAGES] == REDOP_NOR) ? ~g_lvl[LEVELS].lnext[0]
                                                     :  g_lvl[LEVELS].lnext[0];

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Self-checking bench for reduce_tree_pipe: directed WIDTH=8 sequences plus
// randomized WIDTH=32 runs against a queue-based reference model.
module tb_reduce_tree_pipe;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   passed;

  // WIDTH=8, REG_EVERY=1 (3 stages)
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_bit;
  logic [7:0] a_in_data;
  logic [1:0] a_in_op, a_out_op;

  // shared stimulus for the two WIDTH=32 instances
  logic        s_in_valid, s_out_ready;
  logic [31:0] s_in_data;
  logic [1:0]  s_in_op;
  logic        b_in_ready, b_out_valid, b_out_bit;
  logic [1:0]  b_out_op;
  logic        c_in_ready, c_out_valid, c_out_bit;
  logic [1:0]  c_out_op;

  reduce_tree_pipe #(.WIDTH(8), .REG_EVERY(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_op(a_in_op),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bit(a_out_bit), .out_op(a_out_op)
  );

  reduce_tree_pipe #(.WIDTH(32), .REG_EVERY(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(b_in_ready), .in_data(s_in_data), .in_op(s_in_op),
    .out_valid(b_out_valid), .out_ready(s_out_ready), .out_bit(b_out_bit), .out_op(b_out_op)
  );

  reduce_tree_pipe #(.WIDTH(32), .REG_EVERY(5)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(c_in_ready), .in_data(s_in_data), .in_op(s_in_op),
    .out_valid(c_out_valid), .out_ready(s_out_ready), .out_bit(c_out_bit), .out_op(c_out_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic [1:0] op;
    logic       exp_bit;
  } vec_t;

  typedef struct {
    logic       res;
    logic [1:0] op;
    int         cyc;
  } sb_t;

  vec_t tbl[4];
  sb_t  qb[$];
  sb_t  qc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic ref_red(input logic [31:0] d, input logic [1:0] op);
    case (op)
      2'b00:   return |d;
      2'b01:   return &d;
      2'b10:   return ^d;
      default: return ~(|d);
    endcase
  endfunction

  task automatic step_a(input logic v, input logic [7:0] d, input logic [1:0] op, input logic ordy);
    @(negedge clk);
    a_in_valid  = v;
    a_in_data   = d;
    a_in_op     = op;
    a_out_ready = ordy;
    #1;
  endtask

  task automatic mon_b(input bit chk_lat);
    sb_t e;
    if (b_out_valid && s_out_ready) begin
      if (qb.size() == 0) chk("b_spurious_out", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_bit", b_out_bit, e.res);
        chk("b_op", b_out_op, e.op);
        if (chk_lat) chk("b_latency", cyc - e.cyc, 3);
      end
    end
    if (s_in_valid && b_in_ready) qb.push_back('{ref_red(s_in_data, s_in_op), s_in_op, cyc});
  endtask

  task automatic mon_c(input bit chk_lat);
    sb_t e;
    if (c_out_valid && s_out_ready) begin
      if (qc.size() == 0) chk("c_spurious_out", 1, 0);
      else begin
        e = qc.pop_front();
        chk("c_bit", c_out_bit, e.res);
        chk("c_op", c_out_op, e.op);
        if (chk_lat) chk("c_latency", cyc - e.cyc, 1);
      end
    end
    if (s_in_valid && c_in_ready) qc.push_back('{ref_red(s_in_data, s_in_op), s_in_op, cyc});
  endtask

  initial begin
    int stale;
    int m;
    total = 0;
    passed = 0;
    cyc = 0;

    tbl[0] = '{8'hFF, 2'b01, 1'b1};
    tbl[1] = '{8'hFE, 2'b01, 1'b0};
    tbl[2] = '{8'h07, 2'b10, 1'b1};
    tbl[3] = '{8'h80, 2'b00, 1'b1};

    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = '0; a_in_op = '0; a_out_ready = 0;
    s_in_valid = 0; s_in_data = '0; s_in_op = '0; s_out_ready = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_bit", a_out_bit, 0);
    chk("rst_out_op", a_out_op, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_c_out_valid", c_out_valid, 0);

    // latency: two NOR items, outputs 3 cycles after each acceptance
    step_a(1, 8'h00, 2'b11, 1);
    chk("lat_rdy0", a_in_ready, 1);
    step_a(1, 8'h10, 2'b11, 1);
    chk("lat_rdy1", a_in_ready, 1);
    step_a(0, 8'h00, 2'b00, 1);
    chk("lat_early", a_out_valid, 0);
    step_a(0, 8'h00, 2'b00, 1);
    chk("lat_t3_valid", a_out_valid, 1);
    chk("lat_t3_bit", a_out_bit, 1);
    chk("lat_t3_op", a_out_op, 2'b11);
    step_a(0, 8'h00, 2'b00, 1);
    chk("lat_t4_valid", a_out_valid, 1);
    chk("lat_t4_bit", a_out_bit, 0);
    step_a(0, 8'h00, 2'b00, 1);
    chk("lat_t5_valid", a_out_valid, 0);

    // streaming from the table: four back-to-back items, gap-free outputs
    for (m = 0; m < 8; m++) begin
      if (m < 4) step_a(1, tbl[m].data, tbl[m].op, 1);
      else       step_a(0, 8'h00, 2'b00, 1);
      if (m < 4) chk("stream_rdy", a_in_ready, 1);
      chk("stream_valid", a_out_valid, (m >= 3) && (m < 7));
      if ((m >= 3) && (m < 7)) begin
        chk("stream_bit", a_out_bit, tbl[m-3].exp_bit);
        chk("stream_op", a_out_op, tbl[m-3].op);
      end
    end

    // backpressure: fill to three, hold, then pop-and-push in one cycle
    step_a(1, 8'h38, 2'b10, 0); chk("bp_rdy0", a_in_ready, 1);
    step_a(1, 8'h0F, 2'b01, 0); chk("bp_rdy1", a_in_ready, 1);
    step_a(1, 8'h01, 2'b00, 0); chk("bp_rdy2", a_in_ready, 1);
    step_a(1, 8'h00, 2'b11, 0);
    chk("bp_full_rdy", a_in_ready, 0);
    chk("bp_hold_valid", a_out_valid, 1);
    chk("bp_hold_bit", a_out_bit, 1);
    chk("bp_hold_op", a_out_op, 2'b10);
    step_a(1, 8'hFF, 2'b01, 0);
    chk("bp_full_rdy2", a_in_ready, 0);
    chk("bp_stable_bit", a_out_bit, 1);
    chk("bp_stable_op", a_out_op, 2'b10);
    step_a(1, 8'h00, 2'b11, 1);
    chk("bp_swap_rdy", a_in_ready, 1);
    chk("bp_swap_valid", a_out_valid, 1);
    step_a(0, 8'h00, 2'b00, 0);
    chk("bp_still_full", a_in_ready, 0);
    chk("bp_b1_bit", a_out_bit, 0);
    chk("bp_b1_op", a_out_op, 2'b01);
    step_a(0, 8'h00, 2'b00, 1);
    chk("bp_drain1_bit", a_out_bit, 0);
    chk("bp_drain1_op", a_out_op, 2'b01);
    step_a(0, 8'h00, 2'b00, 1);
    chk("bp_drain2_bit", a_out_bit, 1);
    chk("bp_drain2_op", a_out_op, 2'b00);
    step_a(0, 8'h00, 2'b00, 1);
    chk("bp_drain3_valid", a_out_valid, 1);
    chk("bp_drain3_bit", a_out_bit, 1);
    chk("bp_drain3_op", a_out_op, 2'b11);
    step_a(0, 8'h00, 2'b00, 1);
    chk("bp_empty", a_out_valid, 0);

    // asynchronous reset with two items in flight
    step_a(1, 8'h80, 2'b00, 0);
    step_a(1, 8'hFF, 2'b01, 0);
    step_a(0, 8'h00, 2'b00, 0);
    step_a(0, 8'h00, 2'b00, 0);
    chk("mr_pre_valid", a_out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_valid_drop", a_out_valid, 0);
    chk("mr_bit_clr", a_out_bit, 0);
    chk("mr_op_clr", a_out_op, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      step_a(0, 8'h00, 2'b00, 1);
      if (a_out_valid) stale++;
    end
    chk("mr_no_stale", stale, 0);
    chk("mr_rdy", a_in_ready, 1);

    // WIDTH=32 sweep: 1000 unstalled items (latency checked), then random valid/ready
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < (ph == 0 ? 1000 : 600); n++) begin
        @(negedge clk);
        s_in_valid  = (ph == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        s_in_data   = $urandom;
        if ($urandom_range(0, 7) == 0) s_in_data = (($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0);
        s_in_op     = 2'($urandom_range(0, 3));
        s_out_ready = (ph == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        if (ph == 0) begin
          chk("b_rdy", b_in_ready, 1);
          chk("c_rdy", c_in_ready, 1);
        end
        mon_b(ph == 0);
        mon_c(ph == 0);
      end
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      s_in_valid  = 1'b0;
      s_out_ready = 1'b1;
      #1;
      mon_b(1'b0);
      mon_c(1'b0);
    end
    chk("b_drained", qb.size(), 0);
    chk("c_drained", qc.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
